data_ram_nbank: RTL and testbench
=================================

# data_ram_nbank

Parametrised banked data RAM for the MA stage, successor to the fixed 4-bank data memory. Serves the CPU load/store port (32-bit word, byte enables) and a wide line port (NBANK×32 bits) used by the DRAM refill/writeback engine. A small arbitration FSM gives the line port priority and stalls the CPU. A req/ack handshake sequences line reads and writes.

## Interface
- `WADR`, 11: CPU word-address width; low `NBANK_LOG` bits select the bank.
- `NBANK_LOG`, 2: log2 of bank count; NBANK = 2^NBANK_LOG, line width LW = 32·NBANK.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_ren` in 1: CPU read request.
- `cpu_radr` in WADR: CPU read word address.
- `cpu_rdata` out 32: CPU read data; valid when `cpu_rvalid`.
- `cpu_rvalid` out 1: read data valid.
- `cpu_wadr` in WADR: CPU write word address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_wen` in 4: CPU byte write enables.
- `cpu_stall` out 1: CPU access is not accepted this cycle.
- `line_req` in 1: line operation request; held until `line_ack`.
- `line_we` in 1: 1 = line write, 0 = line read; stable while `line_req` is high.
- `line_adr` in WADR-NBANK_LOG: line index.
- `line_wdata` in LW: line write data; bank b occupies bits [32b+31:32b].
- `line_rdata` out LW: line read data; valid when `line_rvalid`.
- `line_rvalid` out 1: line read data valid.
- `line_ack` out 1: one-cycle completion pulse.

## Operation
- Storage: NBANK banks, each 2^(WADR-NBANK_LOG) × 32 bits with byte write enables. Synchronous read, 1-cycle latency. Contents are not reset.
- `cpu_stall = rst | line_req | (state != IDLE)`.
- CPU write is accepted when `|cpu_wen & ~cpu_stall`. It writes bank `cpu_wadr[NBANK_LOG-1:0]`, row `cpu_wadr[WADR-1:NBANK_LOG]`, with the enabled bytes only.
- CPU read is accepted when `cpu_ren & ~cpu_stall`. The bank-select register captures the bank index. Next cycle: `cpu_rvalid=1` and `cpu_rdata` = the selected bank's output.
- A CPU access during a stall is ignored; the CPU holds and retries.
- FSM states and transitions:
  - IDLE: if `line_req`, latch `line_adr`/`line_wdata`, then go to LINE_WR (`line_we=1`) or LINE_RD (`line_we=0`).
  - LINE_WR: write all banks, all bytes, at the latched index; `line_ack=1`; go to IDLE.
  - LINE_RD: read all banks at the latched index; go to LINE_RSP.
  - LINE_RSP: `line_rdata` = concatenated bank outputs; `line_rvalid=1`, `line_ack=1`; go to IDLE.
- Requester rule: `line_req` is low in the cycle after `line_ack`. A new request may follow from the cycle after that.
- Simultaneous CPU read and write to the same word: behaviour is set by the configuration macro.
- CPU read and write to different words in the same cycle: both are performed.

## Timing
- CPU read latency: 1 cycle.
- Line write: `line_ack` in cycle N+1 after `line_req` is first seen at N.
- Line read: `line_ack` and `line_rvalid` in cycle N+2.
- `cpu_stall` rises combinationally with `line_req` and stays high until the IDLE return.
- Reset values: state IDLE, bank-select register 0, `cpu_rvalid`/`line_ack`/`line_rvalid` = 0, `cpu_stall` = 1 while `rst` is asserted.
- Reset mid-operation: the FSM returns to IDLE and the pending line operation is abandoned with no ack. If reset coincides with the write edge, the array write is not guaranteed.

## Configuration
- `DATA_RAM_BYPASS_EN`:
  - Defined: a same-word CPU read and write in one cycle returns the merged data next cycle (new bytes where `cpu_wen` is set, old bytes otherwise). Implemented with a registered `cpu_wdata`/`cpu_wen` plus a hit flag.
  - Undefined: the read returns the pre-write (old) data.

## Structure
- Package `data_ram_pkg` holds:
  - the FSM state enum (IDLE, LINE_WR, LINE_RD, LINE_RSP);
  - constants for NBANK, LW and row-width derivation;
  - bank-slice helper.
- Sub-module `data_bank_1r1w` is a single 1R1W 32-bit bank with 4 byte enables, instantiated NBANK times in a generate loop.

## Test plan
- CPU write 0xDEADBEEF, `cpu_wen=4'hF`, to word 5 (bank 1, row 1); read word 5 → `cpu_rvalid` one cycle later, `cpu_rdata`=0xDEADBEEF.
- Byte enables: word 5 holds 0xDEADBEEF; write 0x11223344 with `cpu_wen=4'b0101` → read returns 0xDE22BE44.
- Line write at index 3, `line_wdata` = {0x33333333, 0x22222222, 0x11111111, 0x00000000} → `line_ack` at N+1; CPU reads of words 12..15 return 0x0, 0x11111111, 0x22222222, 0x33333333.
- CPU writes 0xA0..0xA3 to words 8..11; line read at index 2 → `line_ack`/`line_rvalid` at N+2, `line_rdata` = {0xA3, 0xA2, 0xA1, 0xA0}.
- `line_req` raised together with a CPU write to word 0 → `cpu_stall=1`, word 0 unchanged; after the IDLE return, the retried write lands.
- Same-cycle read/write of word 7 (old 0x0, new 0x5A5A5A5A): without the macro → 0x0; with `DATA_RAM_BYPASS_EN` → 0x5A5A5A5A. Also assert `rst` in LINE_RD → no `line_ack`, state IDLE, `cpu_stall` follows `line_req` after release.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared types and sizing helpers for the banked MA-stage data RAM.
// The top module reads the optional DATA_RAM_BYPASS_EN macro; this package does not depend on it.
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LINE_WR  = 2'd1,
        LINE_RD  = 2'd2,
        LINE_RSP = 2'd3
    } ram_state_e;

    localparam int WORD_W        = 32;
    localparam int WADR_DEF      = 11;
    localparam int NBANK_LOG_DEF = 2;

    function automatic int nbank(input int nbank_log);
        return 1 << nbank_log;
    endfunction

    function automatic int line_w(input int nbank_log);
        return WORD_W * nbank(nbank_log);
    endfunction

    // Each bank holds one word per line, so the row index is the address minus the bank bits.
    function automatic int row_w(input int wadr, input int nbank_log);
        return wadr - nbank_log;
    endfunction

    // Returns the LSB of bank b's word within a line vector.
    function automatic int bank_lsb(input int b);
        return WORD_W * b;
    endfunction

endpackage

// File: rtl/data_bank_1r1w.sv
// A single 32-bit data bank with one synchronous read port and one byte-enabled write port.
// Storage has no reset. A read and a write to the same row in one cycle return the old data.
module data_bank_1r1w #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] radr,
    output logic [31:0]   rdata,
    input  logic [3:0]    we,
    input  logic [AW-1:0] wadr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[radr];
        for (int i = 0; i < 4; i++)
            if (we[i])
                mem[wadr][8*i +: 8] <= wdata[8*i +: 8];
    end

endmodule

// File: rtl/data_ram_nbank.sv
// Banked MA-stage data RAM: a CPU word port plus a line port for refill and writeback; line operations stall the CPU.
// Define DATA_RAM_BYPASS_EN so a same-word CPU read and write return the merged data; otherwise the read returns the old data.
module data_ram_nbank
    import data_ram_pkg::*;
#(
    parameter  int WADR      = WADR_DEF,
    parameter  int NBANK_LOG = NBANK_LOG_DEF,
    localparam int NBANK     = nbank(NBANK_LOG),
    localparam int LW        = line_w(NBANK_LOG),
    localparam int RW        = row_w(WADR, NBANK_LOG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_ren,
    input  logic [WADR-1:0] cpu_radr,
    output logic [31:0]     cpu_rdata,
    output logic            cpu_rvalid,
    input  logic [WADR-1:0] cpu_wadr,
    input  logic [31:0]     cpu_wdata,
    input  logic [3:0]      cpu_wen,
    output logic            cpu_stall,
    input  logic            line_req,
    input  logic            line_we,
    input  logic [RW-1:0]   line_adr,
    input  logic [LW-1:0]   line_wdata,
    output logic [LW-1:0]   line_rdata,
    output logic            line_rvalid,
    output logic            line_ack
);

    ram_state_e state, state_nxt;
    logic       latch_req, line_wr_all, line_rd_all;

    logic [RW-1:0]        line_adr_q;
    logic [LW-1:0]        line_wdata_q;
    logic [NBANK_LOG-1:0] bank_sel;
    logic [NBANK-1:0][31:0] bank_rdata;

    logic                 cpu_rd_acc, cpu_wr_acc;
    logic [NBANK_LOG-1:0] rbank, wbank;
    logic [RW-1:0]        rrow, wrow;

    assign cpu_stall  = rst | line_req | (state != IDLE);
    assign cpu_rd_acc = cpu_ren & ~cpu_stall;
    assign cpu_wr_acc = (|cpu_wen) & ~cpu_stall;

    assign rbank = cpu_radr[NBANK_LOG-1:0];
    assign rrow  = cpu_radr[WADR-1:NBANK_LOG];
    assign wbank = cpu_wadr[NBANK_LOG-1:0];
    assign wrow  = cpu_wadr[WADR-1:NBANK_LOG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch_req   = 1'b0;
        line_wr_all = 1'b0;
        line_rd_all = 1'b0;
        line_ack    = 1'b0;
        line_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (line_req) begin
                    latch_req = 1'b1;
                    state_nxt = line_we ? LINE_WR : LINE_RD;
                end
            end
            LINE_WR: begin
                line_wr_all = 1'b1;
                line_ack    = 1'b1;
                state_nxt   = IDLE;
            end
            LINE_RD: begin
                line_rd_all = 1'b1;
                state_nxt   = LINE_RSP;
            end
            LINE_RSP: begin
                line_ack    = 1'b1;
                line_rvalid = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The request inputs may change once acked, so the FSM works from its own copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_adr_q   <= '0;
            line_wdata_q <= '0;
        end else if (latch_req) begin
            line_adr_q   <= line_adr;
            line_wdata_q <= line_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel   <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_rd_acc;
            if (cpu_rd_acc)
                bank_sel <= rbank;
        end
    end

    // A line operation stalls the CPU, so line and CPU never compete for a bank port.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic          re_b;
        logic [3:0]    we_b;
        logic [RW-1:0] radr_b, wadr_b;
        logic [31:0]   wdata_b;

        always_comb begin
            we_b    = 4'h0;
            wadr_b  = wrow;
            wdata_b = cpu_wdata;
            if (line_wr_all) begin
                we_b    = 4'hF;
                wadr_b  = line_adr_q;
                wdata_b = line_wdata_q[bank_lsb(b) +: 32];
            end else if (cpu_wr_acc && (wbank == NBANK_LOG'(b))) begin
                we_b = cpu_wen;
            end
        end

        assign re_b   = line_rd_all | (cpu_rd_acc & (rbank == NBANK_LOG'(b)));
        assign radr_b = line_rd_all ? line_adr_q : rrow;

        data_bank_1r1w #(.AW(RW)) u_bank (
            .clk   (clk),
            .re    (re_b),
            .radr  (radr_b),
            .rdata (bank_rdata[b]),
            .we    (we_b),
            .wadr  (wadr_b),
            .wdata (wdata_b)
        );
    end

    assign line_rdata = bank_rdata;

`ifdef DATA_RAM_BYPASS_EN
    logic        byp_hit;
    logic [31:0] byp_wdata;
    logic [3:0]  byp_wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_hit   <= 1'b0;
            byp_wdata <= '0;
            byp_wen   <= '0;
        end else begin
            byp_hit   <= cpu_rd_acc & cpu_wr_acc & (cpu_radr == cpu_wadr);
            byp_wdata <= cpu_wdata;
            byp_wen   <= cpu_wen;
        end
    end

    // The bank still returns the pre-write word; overlay the bytes written in the same cycle.
    always_comb begin
        cpu_rdata = bank_rdata[bank_sel];
        if (byp_hit)
            for (int i = 0; i < 4; i++)
                if (byp_wen[i])
                    cpu_rdata[8*i +: 8] = byp_wdata[8*i +: 8];
    end
`else
    assign cpu_rdata = bank_rdata[bank_sel];
`endif

endmodule

// File: tb/tb_data_ram_nbank.sv
// Self-checking bench for data_ram_nbank: directed cases, then random CPU and line traffic checked against a word-array model.
// The bench reads the same DATA_RAM_BYPASS_EN macro as the design to choose the expected same-word read result.
module tb_data_ram_nbank;
    localparam int WADR      = 11;
    localparam int NBANK_LOG = 2;
    localparam int NBANK     = 4;
    localparam int LW        = 128;
    localparam int NW        = 1 << WADR;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cpu_ren;
    logic [WADR-1:0]         cpu_radr;
    logic [31:0]             cpu_rdata;
    logic                    cpu_rvalid;
    logic [WADR-1:0]         cpu_wadr;
    logic [31:0]             cpu_wdata;
    logic [3:0]              cpu_wen;
    logic                    cpu_stall;
    logic                    line_req;
    logic                    line_we;
    logic [WADR-NBANK_LOG-1:0] line_adr;
    logic [LW-1:0]           line_wdata;
    logic [LW-1:0]           line_rdata;
    logic                    line_rvalid;
    logic                    line_ack;

    always #5 clk = ~clk;

    data_ram_nbank #(.WADR(WADR), .NBANK_LOG(NBANK_LOG)) dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_radr(cpu_radr), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .cpu_wadr(cpu_wadr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen), .cpu_stall(cpu_stall),
        .line_req(line_req), .line_we(line_we), .line_adr(line_adr), .line_wdata(line_wdata),
        .line_rdata(line_rdata), .line_rvalid(line_rvalid), .line_ack(line_ack)
    );

    logic [31:0] mem [NW];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic cpu_cycle(input bit ren, input logic [WADR-1:0] radr, input logic [3:0] wen,
                             input logic [WADR-1:0] wadr, input logic [31:0] wdata);
        logic [31:0] exp_rd;
        @(negedge clk);
        cpu_ren = ren; cpu_radr = radr; cpu_wen = wen; cpu_wadr = wadr; cpu_wdata = wdata;
        #1 chk("stall_idle", cpu_stall, 0);
        exp_rd = mem[radr];
`ifdef DATA_RAM_BYPASS_EN
        if (ren && wen != 4'h0 && radr == wadr) exp_rd = merge(mem[radr], wdata, wen);
`endif
        @(posedge clk);
        if (wen != 4'h0) mem[wadr] = merge(mem[wadr], wdata, wen);
        #1;
        cpu_ren = 1'b0; cpu_wen = 4'h0;
        chk("cpu_rvalid", cpu_rvalid, ren);
        if (ren) chk("cpu_rdata", cpu_rdata, exp_rd);
    endtask

    // CPU write inputs (try_*) are held for the whole operation, as a stalled CPU would.
    task automatic line_op(input bit we, input int idx, input logic [LW-1:0] wd,
                           input logic [3:0] try_wen, input logic [WADR-1:0] try_wadr, input logic [31:0] try_wdata);
        logic [LW-1:0] exp_line;
        @(negedge clk);
        line_req = 1'b1; line_we = we; line_adr = (WADR-NBANK_LOG)'(idx); line_wdata = wd;
        cpu_wen = try_wen; cpu_wadr = try_wadr; cpu_wdata = try_wdata;
        #1 chk("stall_req", cpu_stall, 1);
        for (int b = 0; b < NBANK; b++) exp_line[32*b +: 32] = mem[idx*NBANK + b];
        @(posedge clk); #1;
        chk("stall_busy", cpu_stall, 1);
        if (we) begin
            chk("ack_wr", line_ack, 1);
            chk("rvalid_wr", line_rvalid, 0);
            for (int b = 0; b < NBANK; b++) mem[idx*NBANK + b] = wd[32*b +: 32];
        end else begin
            chk("ack_early", line_ack, 0);
            @(posedge clk); #1;
            chk("ack_rd", line_ack, 1);
            chk("rvalid_rd", line_rvalid, 1);
            chk("line_rdata", line_rdata, exp_line);
        end
        line_req = 1'b0; line_we = 1'b0;
        @(posedge clk); #1;
        chk("stall_done", cpu_stall, 0);
        chk("ack_done", line_ack, 0);
        cpu_wen = 4'h0;
        @(posedge clk);
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [WADR-1:0] ra, wa;
        rst = 1'b1; cpu_ren = 1'b0; cpu_radr = '0; cpu_wadr = '0; cpu_wdata = '0; cpu_wen = '0;
        line_req = 1'b0; line_we = 1'b0; line_adr = '0; line_wdata = '0;
        #1;
        chk("rst_stall", cpu_stall, 1);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_ack", line_ack, 0);
        chk("rst_lrvalid", line_rvalid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk("rel_stall", cpu_stall, 0);

        // Give the whole array known contents through the line port.
        for (int i = 0; i < NW / NBANK; i++) line_op(1'b1, i, '0, 4'h0, '0, '0);

        cpu_cycle(1'b0, 11'd0, 4'hF, 11'd5, 32'hDEADBEEF);
        cpu_cycle(1'b1, 11'd5, 4'h0, 11'd0, 32'h0);
        chk("tp_word5", cpu_rdata, 32'hDEADBEEF);
        cpu_cycle(1'b0, 11'd0, 4'b0101, 11'd5, 32'h11223344);
        cpu_cycle(1'b1, 11'd5, 4'h0, 11'd0, 32'h0);
        chk("tp_byte_en", cpu_rdata, 32'hDE22BE44);

        line_op(1'b1, 3, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, 4'h0, '0, '0);
        cpu_cycle(1'b1, 11'd12, 4'h0, 11'd0, 32'h0); chk("tp_w12", cpu_rdata, 32'h0);
        cpu_cycle(1'b1, 11'd13, 4'h0, 11'd0, 32'h0); chk("tp_w13", cpu_rdata, 32'h11111111);
        cpu_cycle(1'b1, 11'd14, 4'h0, 11'd0, 32'h0); chk("tp_w14", cpu_rdata, 32'h22222222);
        cpu_cycle(1'b1, 11'd15, 4'h0, 11'd0, 32'h0); chk("tp_w15", cpu_rdata, 32'h33333333);

        for (int i = 0; i < 4; i++) cpu_cycle(1'b0, 11'd0, 4'hF, 11'(8 + i), 32'hA0 + 32'(i));
        line_op(1'b0, 2, '0, 4'h0, '0, '0);
        chk("tp_line_rd", line_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        line_op(1'b0, 7, '0, 4'hF, 11'd0, 32'hCAFEF00D);
        cpu_cycle(1'b1, 11'd0, 4'h0, 11'd0, 32'h0);
        chk("tp_stall_w0", cpu_rdata, 32'h0);
        cpu_cycle(1'b0, 11'd0, 4'hF, 11'd0, 32'hCAFEF00D);
        cpu_cycle(1'b1, 11'd0, 4'h0, 11'd0, 32'h0);
        chk("tp_retry_w0", cpu_rdata, 32'hCAFEF00D);

        cpu_cycle(1'b1, 11'd7, 4'hF, 11'd7, 32'h5A5A5A5A);
`ifdef DATA_RAM_BYPASS_EN
        chk("tp_rw_same", cpu_rdata, 32'h5A5A5A5A);
`else
        chk("tp_rw_same", cpu_rdata, 32'h0);
`endif
        cpu_cycle(1'b1, 11'd7, 4'h0, 11'd0, 32'h0);
        chk("tp_rw_after", cpu_rdata, 32'h5A5A5A5A);

        // Reset while a line read is in LINE_RD: the operation is dropped without an ack.
        @(negedge clk);
        line_req = 1'b1; line_we = 1'b0; line_adr = 9'd4;
        @(posedge clk); #1;
        chk("mid_ack0", line_ack, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", cpu_stall, 1);
        chk("mid_rst_ack", line_ack, 0);
        chk("mid_rst_lrv", line_rvalid, 0);
        line_req = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ack2", line_ack, 0);
        chk("mid_rst_lrv2", line_rvalid, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("mid_rel_idle", cpu_stall, 0);
        @(posedge clk); #1;
        chk("mid_no_ack", line_ack, 0);
        line_op(1'b1, 4, rnd_line(), 4'h0, '0, '0);
        line_op(1'b0, 4, '0, 4'h0, '0, '0);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                line_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rnd_line(),
                        4'($urandom_range(0, 15)), 11'($urandom_range(0, 63)), $urandom());
            end else begin
                ra = 11'($urandom_range(0, 63));
                wa = ($urandom_range(0, 2) == 0) ? ra : 11'($urandom_range(0, 63));
                cpu_cycle(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), wa, $urandom());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
